// File: rtl/spi_target_if.sv
// spi_target_if: SPI pin bundle between initiator and target.
// master drives sck/cs/mosi, slave drives miso/miso_oe.
interface spi_target_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sck,
    output cs,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sck,
    input  cs,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: oversampled mode-3 SPI target endpoint.
// Receives command bytes on MOSI, returns a latched response on MISO.
module spi_target #(
  parameter int CMD_BYTES = 1,
  parameter int RSP_BYTES = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  spi_target_if.slave            spi,
  output logic [7:0]             cmd_byte,
  output logic                   cmd_valid,
  input  logic [8*RSP_BYTES-1:0] rsp_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int TXW = 8 * RSP_BYTES;
  localparam logic [2:0] CMD_N = 3'(CMD_BYTES);
  localparam logic [5:0] RSP_N = 6'(TXW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_RSP,
    S_OVER
  } state_t;

  // [0],[1] synchronizer, [2] history
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;

  // vld marks synchronizer holding real samples;
  // armed means CS has been seen high since reset
  logic [1:0] vld_q, vld_d;
  logic       armed_q, armed_d;

  state_t           state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [TXW-1:0]   tx_q, tx_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       cs_lo;
  logic       sck_rise;
  logic       sck_fall;
  logic       cs_rise;
  logic       cs_fall;
  logic       mosi_s;
  logic [7:0] shifted;
  logic [2:0] byte_inc;
  logic [5:0] cnt_inc;

  // synchronizer shift and edge pulses
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi.sck};
    cs_sync_d   = {cs_sync_q[1:0], spi.cs};
    mosi_sync_d = {mosi_sync_q[1:0], spi.mosi};
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q | (vld_q[1] & cs_sync_q[1]);
    cs_lo    = ~cs_sync_q[1];
    sck_rise = cs_lo & sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall = cs_lo & ~sck_sync_q[1] & sck_sync_q[2];
    cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    mosi_s   = mosi_sync_q[2];
  end

  // frame FSM next-state and output logic
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    shifted     = {shift_q[6:0], mosi_s};
    byte_inc    = byte_q + 3'd1;
    cnt_inc     = cnt_q + 6'd1;

    if (state_q != S_IDLE && cs_rise) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      done_d  = (state_q == S_OVER);
      err_d   = (state_q != S_OVER);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
          if (cs_fall && armed_q) begin
            busy_d  = 1'b1;
            oe_d    = 1'b1;
            bit_d   = 3'd7;
            byte_d  = 3'd0;
            cnt_d   = 6'd0;
            shift_d = 8'd0;
            state_d = S_CMD;
          end
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            shift_d = shifted;
            if (bit_q == 3'd0) begin
              cmd_byte_d  = shifted;
              cmd_valid_d = 1'b1;
              bit_d       = 3'd7;
              byte_d      = byte_inc;
              if (byte_inc == CMD_N)
                state_d = S_LOAD;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
        S_LOAD: begin
          tx_d    = rsp_data;
          state_d = S_RSP;
        end
        S_RSP: begin
          if (sck_fall) begin
            miso_d = tx_q[TXW-1];
            tx_d   = tx_q << 1;
          end
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_inc == RSP_N)
              state_d = S_OVER;
          end
        end
        S_OVER: begin
          if (sck_fall)
            miso_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state, counters, synchronizers and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 3'b111;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bit_q       <= 3'd7;
      byte_q      <= 3'd0;
      cnt_q       <= 6'd0;
      shift_q     <= 8'd0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = oe_q;
  assign cmd_byte    = cmd_byte_q;
  assign cmd_valid   = cmd_valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule
